// File: rtl/scan_pkg.sv
// Shared types and defaults for the scan-chain sequencer.
package scan_pkg;
  localparam int SCAN_CHAIN_LEN_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } scan_state_t;
endpackage

// File: rtl/scan_bitcnt.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module scan_bitcnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 count <= '0;
    else if (load)              count <= load_val;
    else if (dec && count != 0) count <= count - 1'b1;
  end

  assign zero = (count == '0);
endmodule

// File: rtl/scan_ctrl.sv
// Scan-chain sequencer: shift pattern in, one capture cycle, shift result out.
// Optional compare-against-Expect feature enabled by SCAN_CTRL_COMPARE_EN.
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = SCAN_CHAIN_LEN_DEF,
  parameter int CNT_W     = $clog2(CHAIN_LEN+1)
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic                 Start,
  input  logic [CHAIN_LEN-1:0] PatIn,
  input  logic                 ChainOut,
  output logic                 Test,
  output logic                 Load,
  output logic                 SDI,
  output logic                 Busy,
  output logic                 Done,
  output logic [CHAIN_LEN-1:0] Result
`ifdef SCAN_CTRL_COMPARE_EN
  ,
  input  logic [CHAIN_LEN-1:0] Expect,
  output logic                 Pass
`endif
);
  scan_state_t          state, state_nxt;
  logic [CHAIN_LEN-1:0] pat_q, result_q;
  logic [CNT_W-1:0]     cnt;
  logic                 cnt_zero, cnt_load, cnt_dec;
  logic                 accept;

  assign accept = (state == IDLE) && Start;

  scan_bitcnt #(.CNT_W(CNT_W)) u_bitcnt (
    .clk      (Clock),
    .rst_n    (nReset),
    .load     (cnt_load),
    .load_val (CNT_W'(CHAIN_LEN-1)),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE:      if (Start) begin state_nxt = SHIFT_IN; cnt_load = 1'b1; end
      SHIFT_IN:  if (cnt_zero) state_nxt = CAPTURE; else cnt_dec = 1'b1;
      CAPTURE:   begin state_nxt = SHIFT_OUT; cnt_load = 1'b1; end
      SHIFT_OUT: if (cnt_zero) state_nxt = DONE; else cnt_dec = 1'b1;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Pattern drains MSB-first; zeros fill behind it so SDI is 0 after SHIFT_IN.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      pat_q    <= '0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept)                 pat_q <= PatIn;
      else if (state == SHIFT_IN) pat_q <= pat_q << 1;
      if (state == SHIFT_OUT)     result_q <= {result_q[CHAIN_LEN-2:0], ChainOut};
    end
  end

`ifdef SCAN_CTRL_COMPARE_EN
  logic [CHAIN_LEN-1:0] exp_q;

  // Verdict is formed on the final shift edge so it is already valid in DONE.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      exp_q <= '0;
      Pass  <= 1'b0;
    end else if (accept) begin
      exp_q <= Expect;
      Pass  <= 1'b0;
    end else if (state == SHIFT_OUT && cnt_zero) begin
      Pass  <= ({result_q[CHAIN_LEN-2:0], ChainOut} == exp_q);
    end
  end
`endif

  assign Test   = (state == SHIFT_IN) || (state == SHIFT_OUT);
  assign Load   = (state == SHIFT_IN) || (state == CAPTURE) || (state == SHIFT_OUT);
  assign Busy   = Load;
  assign Done   = (state == DONE);
  assign SDI    = pat_q[CHAIN_LEN-1];
  assign Result = result_q;
endmodule
